// File: rtl/download_line_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : download_line_buffer_pkg                                   |
// | Purpose  : Shared command codes, FSM encoding and default widths for  |
// |            the SDRAM-to-LCD ping-pong line buffer.                    |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package download_line_buffer_pkg;

    localparam int c_DEF_ADDR_WIDTH = 11;
    localparam int c_DEF_DATA_WIDTH = 16;

    // Commands carried on the announce channel
    typedef enum logic [1:0] {
        CMD_NOP         = 2'd0,
        CMD_FRAME_START = 2'd1,
        CMD_LINE_DONE   = 2'd2,
        CMD_RESERVED    = 2'd3
    } cmd_e;

    // Handshake state machine encoding
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE    = 2'd0;
    localparam state_t c_ST_EXEC    = 2'd1;
    localparam state_t c_ST_RELEASE = 2'd2;

    // Commands that move banks and must be forwarded downstream
    function automatic logic is_transfer(input cmd_e cmd);
        return (cmd == CMD_FRAME_START) || (cmd == CMD_LINE_DONE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/download_line_buffer_line_bank_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : download_line_buffer_line_bank_ram                         |
// | Purpose  : Simple dual-port RAM holding both line banks; the bank bit |
// |            is the address MSB. One write port, one registered read.   |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module download_line_buffer_line_bank_ram
    import download_line_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH:0]   i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH:0]   i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int c_DEPTH = 2 ** (ADDR_WIDTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Write port: storage itself is never cleared
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; only the output register is cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/download_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : download_line_buffer                                       |
// | Purpose  : Ping-pong line buffer between the SDRAM framebuffer reader |
// |            and LCD scan-out, with a back-pressured command channel    |
// |            that swaps banks and forwards commands downstream.         |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module download_line_buffer
    import download_line_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int LOG_LEVEL  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_data_en,
    input  logic [ADDR_WIDTH-1:0] lcd_addr,
    output logic [DATA_WIDTH-1:0] lcd_data,
    input  logic [1:0]            command_data_in,
    input  logic                  command_available_in,
    output logic                  buffer_rdy,
    output logic [1:0]            command_data_out,
    output logic                  command_available_out,
    input  logic                  command_ack
);

    // Verbosity only matters to simulation models; nothing is built from it
    if (LOG_LEVEL != 0) begin : g_log_on
    end else begin : g_log_off
    end

    state_t                r_state;
    state_t                w_next_state;
    cmd_e                  r_cmd;
    logic                  r_wr_bank;
    logic                  r_out_pending;
    logic                  r_buffer_rdy;
    logic [1:0]            r_cmd_out;
    logic                  w_clear;
    logic                  w_pending_eff;
    logic                  w_accept;
    logic                  w_launch;
    logic [DATA_WIDTH-1:0] w_lcd_data;

    assign w_clear = reset | init;

    // FSM state register
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: one acceptance per held request
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:    if (command_available_in) w_next_state = c_ST_EXEC;
            c_ST_EXEC:    if (w_accept) w_next_state = c_ST_RELEASE;
            c_ST_RELEASE: if (!command_available_in) w_next_state = c_ST_IDLE;
            default:      w_next_state = c_ST_IDLE;
        endcase
    end

    // FSM outputs: an ack arriving this cycle frees the channel before EXEC looks at it
    always_comb begin
        w_pending_eff = r_out_pending & ~command_ack;
        w_accept      = 1'b0;
        w_launch      = 1'b0;
        if (r_state == c_ST_EXEC) begin
            if (!is_transfer(r_cmd)) begin
                w_accept = 1'b1;
            end else if (!w_pending_eff) begin
                w_accept = 1'b1;
                w_launch = 1'b1;
            end
        end
    end

    // Capture the command when the request is first seen in IDLE
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_cmd <= CMD_NOP;
        end else if ((r_state == c_ST_IDLE) && command_available_in) begin
            r_cmd <= cmd_e'(command_data_in);
        end
    end

    // Bank selection, acknowledge pulse and downstream command channel
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wr_bank     <= 1'b0;
            r_out_pending <= 1'b0;
            r_buffer_rdy  <= 1'b0;
            r_cmd_out     <= 2'd0;
        end else begin
            r_buffer_rdy <= w_accept;
            if (w_launch) begin
                r_wr_bank     <= (r_cmd == CMD_FRAME_START) ? 1'b0 : ~r_wr_bank;
                r_cmd_out     <= r_cmd;
                r_out_pending <= 1'b1;
            end else if (command_ack && r_out_pending) begin
                r_out_pending <= 1'b0;
            end
        end
    end

    // Memory side writes the current bank, LCD side reads the other one
    download_line_buffer_line_bank_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst       (w_clear),
        .i_wr_en   (mem_data_en),
        .i_wr_addr ({r_wr_bank, mem_addr}),
        .i_wr_data (mem_data),
        .i_rd_addr ({~r_wr_bank, lcd_addr}),
        .o_rd_data (w_lcd_data)
    );

    assign lcd_data              = w_lcd_data;
    assign buffer_rdy            = r_buffer_rdy;
    assign command_data_out      = r_cmd_out;
    assign command_available_out = r_out_pending;

endmodule
`default_nettype wire

// File: tb/tb_download_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_download_line_buffer                                    |
// | Purpose  : Self-checking bench for download_line_buffer: reference    |
// |            model compared every cycle plus directed literal checks.   |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_download_line_buffer;

    localparam int AW     = 11;
    localparam int DW     = 16;
    localparam int NPIX   = 480;
    localparam int NLINES = 21;

    localparam int HS_WAIT = 0;
    localparam int HS_HELD = 1;
    localparam int HS_DONE = 2;

    logic          clk;
    logic          reset;
    logic          init;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_data_en;
    logic [AW-1:0] lcd_addr;
    logic [DW-1:0] lcd_data;
    logic [1:0]    command_data_in;
    logic          command_available_in;
    logic          buffer_rdy;
    logic [1:0]    command_data_out;
    logic          command_available_out;
    logic          command_ack;

    logic [DW-1:0] line_px [0:NLINES-1][0:NPIX-1];

    int n_total = 0;
    int n_bad   = 0;

    download_line_buffer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LOG_LEVEL  (0)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .init                  (init),
        .mem_addr              (mem_addr),
        .mem_data              (mem_data),
        .mem_data_en           (mem_data_en),
        .lcd_addr              (lcd_addr),
        .lcd_data              (lcd_data),
        .command_data_in       (command_data_in),
        .command_available_in  (command_available_in),
        .buffer_rdy            (buffer_rdy),
        .command_data_out      (command_data_out),
        .command_available_out (command_available_out),
        .command_ack           (command_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Two flat banks indexed {bank, addr}; a location is only compared once written.
    logic [DW-1:0] m_mem [0:(2**(AW+1))-1];
    bit            m_val [0:(2**(AW+1))-1];
    bit            m_live = 0;
    bit            m_wb   = 0;
    bit            m_pend = 0;
    bit            m_rdy  = 0;
    logic [1:0]    m_dout = 2'd0;
    logic [1:0]    m_cmd  = 2'd0;
    int            m_hs   = HS_WAIT;
    logic [DW-1:0] m_lcd  = '0;
    bit            m_lcd_known = 0;

    always @(posedge clk) begin : model
        logic [AW:0]   ra;
        logic [DW-1:0] rv;
        bit            rk;
        ra = {~m_wb, lcd_addr};
        rv = m_mem[ra];
        rk = m_val[ra];
        if (mem_data_en === 1'b1) begin
            m_mem[{m_wb, mem_addr}] = mem_data;
            m_val[{m_wb, mem_addr}] = 1'b1;
        end
        if (reset || init) begin
            m_live      = 1'b1;
            m_wb        = 1'b0;
            m_pend      = 1'b0;
            m_rdy       = 1'b0;
            m_dout      = 2'd0;
            m_hs        = HS_WAIT;
            m_lcd       = '0;
            m_lcd_known = 1'b1;
        end else if (m_live) begin
            m_lcd       = rv;
            m_lcd_known = rk;
            m_rdy       = 1'b0;
            if (command_ack && m_pend) m_pend = 1'b0;
            case (m_hs)
                HS_WAIT: begin
                    if (command_available_in) begin
                        m_cmd = command_data_in;
                        m_hs  = HS_HELD;
                    end
                end
                HS_HELD: begin
                    if (m_cmd == 2'd0 || m_cmd == 2'd3) begin
                        m_rdy = 1'b1;
                        m_hs  = HS_DONE;
                    end else if (!m_pend) begin
                        m_wb   = (m_cmd == 2'd1) ? 1'b0 : ~m_wb;
                        m_dout = m_cmd;
                        m_pend = 1'b1;
                        m_rdy  = 1'b1;
                        m_hs   = HS_DONE;
                    end
                end
                default: begin
                    if (!command_available_in) m_hs = HS_WAIT;
                end
            endcase
        end
    end

    // Compare every cycle once the model has seen reset
    always @(negedge clk) begin
        if (m_live) begin
            chk("m_buffer_rdy", buffer_rdy, m_rdy);
            chk("m_avail_out", command_available_out, m_pend);
            chk("m_cmd_out", command_data_out, m_dout);
            if (m_lcd_known) chk("m_lcd_data", lcd_data, m_lcd);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_rdy(input string name, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            if (buffer_rdy === 1'b1) seen = 1'b1;
            else tick();
        end
        if (!seen && buffer_rdy === 1'b1) seen = 1'b1;
        chk(name, seen, 1);
    endtask

    task automatic do_swap(input bit ack_first);
        if (ack_first) begin
            command_ack = 1'b1;
            tick();
            command_ack = 1'b0;
            chk("ack_clears_avail", command_available_out, 0);
        end
        command_data_in      = 2'd2;
        command_available_in = 1'b1;
        if (!ack_first) begin
            repeat (3) begin
                tick();
                chk("stall_no_rdy", buffer_rdy, 0);
            end
            command_ack = 1'b1;
            tick();
            command_ack = 1'b0;
        end
        wait_rdy("swap_rdy", 4);
        chk("swap_cmd_out", command_data_out, 2);
        chk("swap_avail_out", command_available_out, 1);
        command_available_in = 1'b0;
        tick();
        chk("swap_rdy_single", buffer_rdy, 0);
    endtask

    task automatic nop_cmd(input logic [1:0] c);
        command_data_in      = c;
        command_available_in = 1'b1;
        tick();
        chk("nop_rdy_early", buffer_rdy, 0);
        tick();
        chk("nop_rdy", buffer_rdy, 1);
        chk("nop_avail_out", command_available_out, 0);
        command_available_in = 1'b0;
        tick();
        chk("nop_rdy_single", buffer_rdy, 0);
        tick();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        for (int l = 0; l < NLINES; l++)
            for (int k = 0; k < NPIX; k++)
                line_px[l][k] = DW'($urandom);

        reset                = 1'b1;
        init                 = 1'b0;
        mem_addr             = '0;
        mem_data             = '0;
        mem_data_en          = 1'b0;
        lcd_addr             = '0;
        command_data_in      = 2'd1;
        command_available_in = 1'b1;
        command_ack          = 1'b0;

        // Reset held two cycles with a request present
        repeat (2) begin
            tick();
            chk("rst_rdy", buffer_rdy, 0);
            chk("rst_avail_out", command_available_out, 0);
            chk("rst_cmd_out", command_data_out, 0);
            chk("rst_lcd", lcd_data, 0);
        end
        command_available_in = 1'b0;
        reset                = 1'b0;
        tick();
        chk("post_rst_rdy", buffer_rdy, 0);

        // Frame start: pulse two cycles after the request, acknowledged once
        command_data_in      = 2'd1;
        command_available_in = 1'b1;
        tick();
        chk("fs_rdy_lat1", buffer_rdy, 0);
        tick();
        chk("fs_rdy_lat2", buffer_rdy, 1);
        chk("fs_cmd_out", command_data_out, 1);
        chk("fs_avail_out", command_available_out, 1);
        repeat (4) begin
            tick();
            chk("fs_no_second_rdy", buffer_rdy, 0);
            chk("fs_avail_held", command_available_out, 1);
        end
        command_available_in = 1'b0;
        tick();

        // Line 0 written in bursts of 16 with 13-cycle gaps
        for (int b = 0; b < NPIX / 16; b++) begin
            for (int i = 0; i < 16; i++) begin
                mem_addr    = AW'(b * 16 + i);
                mem_data    = line_px[0][b * 16 + i];
                mem_data_en = 1'b1;
                tick();
            end
            mem_data_en = 1'b0;
            repeat (13) tick();
        end

        // LINE_DONE stalls behind the unacknowledged frame start
        do_swap(1'b0);

        // Read line L while writing line L+1, then swap
        for (int l = 0; l < NLINES - 1; l++) begin
            for (int k = 0; k < NPIX; k++) begin
                lcd_addr    = AW'(k);
                mem_addr    = AW'(k);
                mem_data    = line_px[l + 1][k];
                mem_data_en = 1'b1;
                tick();
                chk("line_read", lcd_data, line_px[l][k]);
            end
            mem_data_en = 1'b0;
            do_swap(l[0]);
        end

        // Init in the middle of a stalled LINE_DONE drops everything
        command_data_in      = 2'd2;
        command_available_in = 1'b1;
        repeat (2) tick();
        init                 = 1'b1;
        command_available_in = 1'b0;
        tick();
        init = 1'b0;
        chk("init_rdy", buffer_rdy, 0);
        chk("init_avail_out", command_available_out, 0);
        chk("init_cmd_out", command_data_out, 0);
        chk("init_lcd", lcd_data, 0);
        repeat (3) begin
            tick();
            chk("init_no_rdy", buffer_rdy, 0);
        end

        // After init the read bank is bank 1, which holds line 19
        lcd_addr = AW'(7);
        tick();
        chk("bank_before_nop", lcd_data, line_px[19][7]);

        nop_cmd(2'd0);
        nop_cmd(2'd3);

        lcd_addr = AW'(7);
        tick();
        chk("bank_after_nop", lcd_data, line_px[19][7]);
        lcd_addr = AW'(300);
        tick();
        chk("bank_after_nop2", lcd_data, line_px[19][300]);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
